// File: rtl/rca_sum_accumulator.sv
// Accumulates groups of 9-bit {cout,sum} beats from the 8-bit ripple-carry adder
// and presents each group total with a sticky overflow flag and a beat count.
module rca_sum_accumulator #(
  parameter int BEATS = 4,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_sum,
  input  logic             in_cout,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic [7:0]       out_count
);

  typedef enum logic {ACC, HOLD} state_t;

  localparam logic [7:0] BEATS_L = 8'(BEATS);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [7:0]       count;

  logic [ACC_W:0]   sum_w;
  logic [7:0]       count_next;
  logic             accept;
  logic             close;

  // One extra bit on the add captures the carry out of bit ACC_W-1.
  always_comb begin
    sum_w      = {1'b0, acc} + {{(ACC_W-8){1'b0}}, in_cout, in_sum};
    count_next = count + 8'd1;
    accept     = in_valid & in_ready;
    close      = (count_next == BEATS_L) | in_last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACC;
      acc       <= '0;
      ovf       <= 1'b0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
      out_count <= '0;
    end else if (state == ACC) begin
      if (accept) begin
        acc   <= sum_w[ACC_W-1:0];
        ovf   <= ovf | sum_w[ACC_W];
        count <= count_next;
        if (close) begin
          state     <= HOLD;
          in_ready  <= 1'b0;
          out_valid <= 1'b1;
          out_acc   <= sum_w[ACC_W-1:0];
          out_ovf   <= ovf | sum_w[ACC_W];
          out_count <= count_next;
        end
      end
    end else begin
      // Result registers keep their values after release; only reset zeroes them.
      if (out_ready) begin
        state     <= ACC;
        in_ready  <= 1'b1;
        out_valid <= 1'b0;
        acc       <= '0;
        ovf       <= 1'b0;
        count     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rca_sum_accumulator.sv
// Drives three accumulator configurations from shared stimulus and checks each
// against a group-level model built on exact integer totals.
module tb_rca_sum_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_sum;
  logic        in_cout;
  logic        in_last;
  logic        out_ready;

  logic        rdy_a, rdy_b, rdy_c;
  logic        vld_a, vld_b, vld_c;
  logic [15:0] acc_a;
  logic [9:0]  acc_b;
  logic [15:0] acc_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic [7:0]  cnt_a, cnt_b, cnt_c;

  int vectors = 0;
  int miscompares = 0;

  // Model state per configuration: 0 = BEATS 4/W 16, 1 = BEATS 4/W 10, 2 = BEATS 1/W 16.
  int m_beats [3] = '{4, 4, 1};
  int m_w     [3] = '{16, 10, 16};
  bit m_hold  [3];
  int m_cnt   [3];
  int m_total [3];
  int m_oacc  [3];
  bit m_oovf  [3];
  int m_ocnt  [3];

  always #5 clk = ~clk;

  rca_sum_accumulator #(.BEATS(4), .ACC_W(16)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_a),
    .in_sum(in_sum), .in_cout(in_cout), .in_last(in_last),
    .out_valid(vld_a), .out_ready(out_ready), .out_acc(acc_a),
    .out_ovf(ovf_a), .out_count(cnt_a)
  );

  rca_sum_accumulator #(.BEATS(4), .ACC_W(10)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_b),
    .in_sum(in_sum), .in_cout(in_cout), .in_last(in_last),
    .out_valid(vld_b), .out_ready(out_ready), .out_acc(acc_b),
    .out_ovf(ovf_b), .out_count(cnt_b)
  );

  rca_sum_accumulator #(.BEATS(1), .ACC_W(16)) u_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_c),
    .in_sum(in_sum), .in_cout(in_cout), .in_last(in_last),
    .out_valid(vld_c), .out_ready(out_ready), .out_acc(acc_c),
    .out_ovf(ovf_c), .out_count(cnt_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] g_rdy, g_vld, g_acc, g_ovf, g_cnt;
    for (int d = 0; d < 3; d++) begin
      case (d)
        0:       begin g_rdy = 32'(rdy_a); g_vld = 32'(vld_a); g_acc = 32'(acc_a); g_ovf = 32'(ovf_a); g_cnt = 32'(cnt_a); end
        1:       begin g_rdy = 32'(rdy_b); g_vld = 32'(vld_b); g_acc = 32'(acc_b); g_ovf = 32'(ovf_b); g_cnt = 32'(cnt_b); end
        default: begin g_rdy = 32'(rdy_c); g_vld = 32'(vld_c); g_acc = 32'(acc_c); g_ovf = 32'(ovf_c); g_cnt = 32'(cnt_c); end
      endcase
      check($sformatf("in_ready[%0d]", d),  g_rdy, 32'(!m_hold[d]));
      check($sformatf("out_valid[%0d]", d), g_vld, 32'(m_hold[d]));
      check($sformatf("out_acc[%0d]", d),   g_acc, 32'(m_oacc[d]));
      check($sformatf("out_ovf[%0d]", d),   g_ovf, 32'(m_oovf[d]));
      check($sformatf("out_count[%0d]", d), g_cnt, 32'(m_ocnt[d]));
    end
  endtask

  // Group total kept as an exact integer: wrapped value is total mod 2^W, and the
  // sticky carry is set exactly when the exact total reaches 2^W.
  task automatic update_model();
    int beat;
    beat = int'({in_cout, in_sum});
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        m_hold[d] = 0; m_cnt[d] = 0; m_total[d] = 0;
        m_oacc[d] = 0; m_oovf[d] = 0; m_ocnt[d] = 0;
      end else if (m_hold[d]) begin
        if (out_ready) begin
          m_hold[d] = 0; m_cnt[d] = 0; m_total[d] = 0;
        end
      end else if (in_valid) begin
        m_total[d] += beat;
        m_cnt[d]   += 1;
        if (m_cnt[d] == m_beats[d] || in_last) begin
          m_hold[d] = 1;
          m_oacc[d] = m_total[d] % (1 << m_w[d]);
          m_oovf[d] = m_total[d] >= (1 << m_w[d]);
          m_ocnt[d] = m_cnt[d];
        end
      end
    end
  endtask

  task automatic cycle(input bit v, input bit [8:0] b, input bit l, input bit r, input bit rst);
    @(negedge clk);
    check_all();
    in_valid  = v;
    {in_cout, in_sum} = b;
    in_last   = l;
    out_ready = r;
    reset     = rst;
    @(posedge clk);
    update_model();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sum = '0; in_cout = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    update_model();

    // Partial group discarded by reset, then a clean group of ones.
    cycle(1, 9'd1, 0, 1, 0);
    cycle(1, 9'd1, 0, 1, 0);
    cycle(0, 9'd0, 0, 1, 1);
    for (int i = 0; i < 4; i++) cycle(1, 9'd1, 0, 1, 0);
    cycle(0, 9'd0, 0, 1, 0);
    cycle(0, 9'd0, 0, 1, 0);

    // Four beats of 511: 0x7FC at 16 bits, overflow at 10 bits.
    for (int i = 0; i < 4; i++) cycle(1, 9'h1FF, 0, 1, 0);
    cycle(0, 9'd0, 0, 1, 0);
    cycle(0, 9'd0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, 9'd1, 0, 1, 0);
    cycle(0, 9'd0, 0, 1, 0);
    cycle(0, 9'd0, 0, 1, 0);

    // Early close with in_last, plus a stray in_last without in_valid.
    cycle(0, 9'h055, 1, 1, 0);
    cycle(1, 9'h010, 0, 1, 0);
    cycle(1, 9'h020, 1, 1, 0);
    cycle(0, 9'd0, 0, 1, 0);
    cycle(1, 9'h07F, 0, 1, 0);

    // Backpressure with in_valid held high.
    for (int i = 0; i < 8; i++) cycle(1, 9'h1FF, 0, 0, 0);
    cycle(1, 9'h003, 0, 1, 0);
    cycle(0, 9'd0, 0, 1, 0);
    cycle(0, 9'd0, 0, 1, 0);

    // Random traffic with bubbles, early closes, backpressure and rare resets.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 9) < 7),
            9'($urandom_range(0, 511)),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 299) == 0));
    end
    cycle(0, 9'd0, 0, 1, 0);
    @(negedge clk);
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
